cdb_arbiter: RTL and testbench

//  Common Data Bus arbiter for the Tomasulo core. Up to N_RS reservation stations raise Req

---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/cdb_arbiter.sv | 98 +++++++++
 tb/tb_cdb_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Constants shared by the Tomasulo blocks: bus widths, the idle-bus marker and
// the station-to-tag numbering used by registrador and res_station_R.
package tomasulo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;

  localparam logic [15:0]      SEM_VALOR = 16'hFFF0;
  localparam logic [TAG_W-1:0] TAG_NONE  = '0;

  // Station i owns tag i+1 so that tag 0 can mean "no producer".
  function automatic int unsigned tag_of(input int unsigned idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotates the eligible mask so index ptr sits at bit 0,
// priority-encodes the lowest set bit, then rotates the result back.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner
);

  logic [N-1:0]     rotated;
  logic [PTR_W-1:0] offset;
  logic [PTR_W:0]   sum;

  always_comb begin
    rotated = N'({eligible, eligible} >> ptr);
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = PTR_W'(i);
    end
    // ptr + offset can exceed N-1 when N is not a power of two, so wrap explicitly.
    sum    = {1'b0, ptr} + {1'b0, offset};
    winner = (32'(sum) >= 32'(N)) ? PTR_W'(32'(sum) - 32'(N)) : sum[PTR_W-1:0];
  end

  assign any = |eligible;

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one finished reservation station per cycle
// round-robin and drives its tag/result on the registered CDB pair.
module cdb_arbiter #(
  parameter int N_RS   = 4,
  parameter int DATA_W = tomasulo_pkg::DATA_W,
  parameter int TAG_W  = tomasulo_pkg::TAG_W
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Flush,
  input  logic [N_RS-1:0]        Req,
  input  logic [N_RS*DATA_W-1:0] Result,
  output logic [N_RS-1:0]        Grant,
  output logic                   CDB_Valid,
  output logic [TAG_W-1:0]       Qi_CDB,
  output logic [DATA_W-1:0]      CDB
);

  import tomasulo_pkg::SEM_VALOR;
  import tomasulo_pkg::TAG_NONE;
  import tomasulo_pkg::tag_of;

  localparam int                PTR_W    = (N_RS > 1) ? $clog2(N_RS) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_RS - 1);
  localparam logic [DATA_W-1:0] CDB_IDLE = DATA_W'(SEM_VALOR);
  localparam logic [TAG_W-1:0]  QI_IDLE  = TAG_W'(TAG_NONE);

  if (N_RS > (2 ** TAG_W) - 1) begin : g_tag_range_check
    $error("cdb_arbiter: N_RS=%0d stations need more tags than TAG_W=%0d provides", N_RS, TAG_W);
  end

  logic [N_RS-1:0]   grant_reg, grant_next;
  logic              valid_reg, valid_next;
  logic [TAG_W-1:0]  qi_reg, qi_next;
  logic [DATA_W-1:0] cdb_reg, cdb_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;

  logic [N_RS-1:0]   eligible;
  logic              any;
  logic [PTR_W-1:0]  winner;
  logic [DATA_W-1:0] result_arr [N_RS];

  for (genvar gi = 0; gi < N_RS; gi++) begin : g_result_unpack
    assign result_arr[gi] = Result[gi*DATA_W +: DATA_W];
  end

  // The station on the bus right now may still hold Req this cycle; mask it.
  assign eligible = Req & ~grant_reg;

  rr_pick #(
    .N     (N_RS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .any      (any),
    .winner   (winner)
  );

  always_comb begin
    grant_next = '0;
    valid_next = 1'b0;
    qi_next    = QI_IDLE;
    cdb_next   = CDB_IDLE;
    ptr_next   = ptr_reg;
    if (Flush) begin
      ptr_next = '0;
    end else if (any) begin
      grant_next = N_RS'(1) << winner;
      valid_next = 1'b1;
      qi_next    = TAG_W'(tag_of(32'(winner)));
      cdb_next   = result_arr[winner];
      ptr_next   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      grant_reg <= '0;
      valid_reg <= 1'b0;
      qi_reg    <= QI_IDLE;
      cdb_reg   <= CDB_IDLE;
      ptr_reg   <= '0;
    end else begin
      grant_reg <= grant_next;
      valid_reg <= valid_next;
      qi_reg    <= qi_next;
      cdb_reg   <= cdb_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign Grant     = grant_reg;
  assign CDB_Valid = valid_reg;
  assign Qi_CDB    = qi_reg;
  assign CDB       = cdb_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a round-robin reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_cdb_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req;
  logic [15:0] res [N];
  logic [63:0] result_bus;
  logic [3:0]  grant;
  logic        cdb_valid;
  logic [2:0]  qi;
  logic [15:0] cdb;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_res_pack
    assign result_bus[gi*16 +: 16] = res[gi];
  end

  cdb_arbiter #(.N_RS(4), .DATA_W(16), .TAG_W(3)) dut (
    .Clock     (clk),
    .Reset     (rst_n),
    .Flush     (flush),
    .Req       (req),
    .Result    (result_bus),
    .Grant     (grant),
    .CDB_Valid (cdb_valid),
    .Qi_CDB    (qi),
    .CDB       (cdb)
  );

  // Reference model: which station is on the bus, and where the next search starts.
  bit          model_on  = 1'b0;
  bit          exp_valid = 1'b0;
  int          exp_idx   = -1;
  int          m_ptr     = 0;
  logic [15:0] exp_cdb   = 16'hFFF0;

  always @(posedge clk) begin
    int w;
    int i;
    w = -1;
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_idx   = -1;
      m_ptr     = 0;
      model_on  = 1'b1;
    end else if (flush) begin
      exp_valid = 1'b0;
      exp_idx   = -1;
      m_ptr     = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (w < 0 && req[i] && !(exp_valid && exp_idx == i)) w = i;
      end
      if (w >= 0) begin
        exp_valid = 1'b1;
        exp_idx   = w;
        exp_cdb   = res[w];
        m_ptr     = (w + 1) % N;
      end else begin
        exp_valid = 1'b0;
        exp_idx   = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]  eg;
    logic [2:0]  eq;
    logic [15:0] ec;
    if (model_on) begin
      eg = exp_valid ? (4'b0001 << exp_idx) : 4'b0000;
      eq = exp_valid ? 3'(exp_idx + 1) : 3'd0;
      ec = exp_valid ? exp_cdb : 16'hFFF0;
      vectors++;
      if (grant !== eg || cdb_valid !== exp_valid || qi !== eq || cdb !== ec) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t: got grant=%b valid=%b qi=%0d cdb=%h, expected grant=%b valid=%b qi=%0d cdb=%h",
                 $time, grant, cdb_valid, qi, cdb, eg, exp_valid, eq, ec);
      end
      if (cdb_valid === 1'b1)
        $display("bcast t=%0t tag=%0d cdb=%h grant=%b", $time, qi, cdb, grant);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_grant"}, 32'(grant), 32'h0);
    check({name, "_valid"}, 32'(cdb_valid), 32'h0);
    check({name, "_qi"},    32'(qi), 32'h0);
    check({name, "_cdb"},   32'(cdb), 32'hFFF0);
  endtask

  int seq3 [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
  int seq4 [6] = '{1, 2, 1, 2, 1, 2};
  logic [3:0] tbl_req   [10] = '{4'hF, 4'h0, 4'h8, 4'h9, 4'h9, 4'h6, 4'h6, 4'h7, 4'h0, 4'hF};
  bit         tbl_flush [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    req   = 4'hF;
    for (int k = 0; k < N; k++) res[k] = 16'h0000;

    // Reset wins over pending requests.
    step(1);
    check_idle("t1_reset");

    rst_n = 1'b1;
    req   = 4'h0;
    step(1);

    // Single request, station drops Req on seeing Grant.
    req    = 4'b0100;
    res[2] = 16'h0015;
    step(1);
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_valid", 32'(cdb_valid), 32'h1);
    check("t2_qi",    32'(qi), 32'h3);
    check("t2_cdb",   32'(cdb), 32'h0015);
    req = 4'b0000;
    step(1);
    check_idle("t2_after");

    // Flush to bring the pointer home, then all four stations hold Req.
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    for (int k = 0; k < N; k++) res[k] = 16'h1000 + 16'(k) * 16'h0111;
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("t3_qi",    32'(qi), 32'(seq3[k]));
      check("t3_grant", 32'(grant), 32'(4'b0001 << (seq3[k] - 1)));
      check("t3_cdb",   32'(cdb), 32'(res[seq3[k] - 1]));
    end
    req = 4'h0;
    step(1);
    check_idle("t3_after");

    // Two stations held high alternate; station 0 never wins twice running.
    req = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("t4_qi", 32'(qi), 32'(seq4[k]));
    end
    req = 4'h0;
    step(1);

    // Grant to station 2 leaves Ptr=3; Flush drops everything and restarts at 0.
    req = 4'b0100;
    step(1);
    check("t5_qi_pre", 32'(qi), 32'h3);
    req   = 4'b0110;
    flush = 1'b1;
    step(1);
    check_idle("t5_flush");
    flush = 1'b0;
    step(1);
    check("t5_qi_post",    32'(qi), 32'h2);
    check("t5_grant_post", 32'(grant), 32'h2);
    req = 4'h0;
    step(1);
    check_idle("t5_after");

    // Reset during a broadcast drops it; held reset blocks the pending request.
    req = 4'b0010;
    step(1);
    check("t6_qi_pre", 32'(qi), 32'h2);
    rst_n = 1'b0;
    step(1);
    check_idle("t6_reset1");
    step(1);
    check_idle("t6_reset2");
    rst_n = 1'b1;
    step(1);
    check("t6_qi_release", 32'(qi), 32'h2);
    check("t6_cdb_release", 32'(cdb), 32'(res[1]));
    req = 4'h0;
    step(1);

    // Mixed table: the per-cycle model carries the checking here.
    for (int k = 0; k < 10; k++) begin
      req   = tbl_req[k];
      flush = tbl_flush[k];
      step(1);
    end
    req   = 4'h0;
    flush = 1'b0;
    step(2);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
